// File: rtl/rom_fetch_unit_pkg.sv
// Shared constants and types for the boot-ROM instruction fetch front end.
package rom_fetch_unit_pkg;

    localparam int ROM_ADDR_W = 9;
    localparam int INSTR_W    = 32;
    localparam logic [31:0]        RESET_VECTOR = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP          = '0;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Fetch is word-granular; the low byte-offset bits are discarded.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/rom_fetch_unit_fetch_fifo.sv
// Small {pc,instr} FIFO between the ROM return path and the decoder.
// Flush empties it in one cycle; head reads zero while empty.
module fetch_fifo
    import rom_fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       head,
    output logic [OCC_W-1:0]   occ
);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [OCC_W-1:0] occ_reg;
    fetch_entry_t     entry_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            occ_reg <= occ_reg + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            fetch_entry_t entry_reg;
            always_ff @(posedge clk) begin
                if (push && !flush && wr_ptr_reg == PTR_W'(gi))
                    entry_reg <= push_data;
            end
            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    assign head = (occ_reg != '0) ? entry_q[rd_ptr_reg] : '0;
    assign occ  = occ_reg;

endmodule

// File: rtl/rom_fetch_unit.sv
// Instruction fetch front end: issues ROM reads, tracks the one in-flight word,
// buffers returns and hands {pc,instr} to the decoder; redirects flush everything.
module rom_fetch_unit
    import rom_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR,
    parameter int          ADDR_W   = ROM_ADDR_W,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic              align_err
);

    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = OCC_W + 1;

    logic        running_reg;
    logic [31:0] fetch_pc_reg;
    logic [31:0] tag_reg;
    logic        inflight_reg;
    logic        align_err_reg;

    logic [OCC_W-1:0] fifo_occ;
    fetch_entry_t     fifo_head;
    fetch_entry_t     push_entry;
    logic             fifo_empty;
    logic             pop;
    logic             fifo_pop;
    logic             push;
    logic             issue;
    logic [CNT_W-1:0] pending;

    assign fifo_empty = (fifo_occ == '0);
    assign out_valid  = !fifo_empty || inflight_reg;
    assign pop        = out_valid && out_ready;
    assign fifo_pop   = pop && !fifo_empty;

    // A returning word goes straight to the decoder when the FIFO is empty,
    // which is what gives rom_en -> out_valid a single cycle.
    assign push = inflight_reg && !redirect && !(fifo_empty && pop);

    // Slots already spoken for after this cycle's pop; never exceed DEPTH.
    assign pending = CNT_W'(fifo_occ) + CNT_W'(inflight_reg) - CNT_W'(pop);
    assign issue   = running_reg && !redirect && (pending < CNT_W'(DEPTH));

    assign rom_en   = issue;
    assign rom_addr = fetch_pc_reg[ADDR_W+1:2];
    assign align_err = align_err_reg;
    assign push_entry = '{pc: tag_reg, instr: rom_data};

    always_comb begin
        out_pc    = 32'h0;
        out_instr = NOP;
        if (!fifo_empty) begin
            out_pc    = fifo_head.pc;
            out_instr = fifo_head.instr;
        end else if (inflight_reg) begin
            out_pc    = tag_reg;
            out_instr = rom_data;
        end
    end

    // Clearing inflight on a redirect is the kill: the word coming back from
    // the read issued before the redirect is never pushed or presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running_reg   <= 1'b0;
            fetch_pc_reg  <= RESET_PC;
            tag_reg       <= 32'h0;
            inflight_reg  <= 1'b0;
            align_err_reg <= 1'b0;
        end else begin
            running_reg   <= 1'b1;
            align_err_reg <= redirect && (redirect_pc[1:0] != 2'b00);
            if (redirect) begin
                fetch_pc_reg <= align_pc(redirect_pc);
                inflight_reg <= 1'b0;
            end else if (issue) begin
                inflight_reg <= 1'b1;
                tag_reg      <= fetch_pc_reg;
                fetch_pc_reg <= fetch_pc_reg + 32'd4;
            end else begin
                inflight_reg <= 1'b0;
            end
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (redirect),
        .head      (fifo_head),
        .occ       (fifo_occ)
    );

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Directed bench for rom_fetch_unit: a monitor pops expected {pc,instr} from a
// scoreboard on every accepted handshake; stimulus checks timing points directly.
module tb_rom_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_en;
    logic [8:0]  rom_addr;
    logic [31:0] rom_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        align_err;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [31:0] rom_mem [512];

    always #5 clk = ~clk;

    rom_fetch_unit #(.RESET_PC(32'h0), .ADDR_W(9), .DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .align_err   (align_err)
    );

    // Boot ROM model: synchronous read port with one cycle of latency.
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_mem[rom_addr];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_one(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    task automatic expect_run(input logic [31:0] pc0, input int n);
        logic [31:0] p;
        for (int i = 0; i < n; i++) begin
            p = pc0 + 32'(4 * i);
            expect_one(p, rom_mem[p[10:2]]);
        end
    endtask

    // Monitor: every accepted head must be the next expected entry.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL pop: got pc=%h instr=%h, expected nothing", out_pc, out_instr);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_pc === mon_e.pc && out_instr === mon_e.instr) begin
                    n_pass++;
                    $display("pop pc=%h instr=%h ok", out_pc, out_instr);
                end else begin
                    $display("FAIL pop: got pc=%h instr=%h, expected pc=%h instr=%h",
                             out_pc, out_instr, mon_e.pc, mon_e.instr);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 512; i++) rom_mem[i] = 32'hA000_0000 | 32'(i);
        rom_mem[0]   = 32'h0800_0010;
        rom_mem[1]   = 32'h0000_0000;
        rom_mem[2]   = 32'h3c08_f060;
        rom_mem[3]   = 32'had00_0000;
        rom_mem[16]  = 32'h3c10_4000;
        rom_mem[511] = 32'hDEAD_BEEF;

        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rom_en",    32'(rom_en),    32'h0);
        chk("rst_rom_addr",  32'(rom_addr),  32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_pc",    out_pc,         32'h0);
        chk("rst_out_instr", out_instr,      32'h0);
        chk("rst_align_err", 32'(align_err), 32'h0);

        // Test 1: sequential fetch from reset
        expect_one(32'h0, 32'h0800_0010);
        expect_one(32'h4, 32'h0000_0000);
        expect_one(32'h8, 32'h3c08_f060);
        expect_one(32'hC, 32'had00_0000);
        expect_run(32'h10, 12);
        nxt(); rst = 1'b0;                                   // cycle 0
        @(negedge clk); chk("c0_rom_en", 32'(rom_en), 32'h0);
        nxt(); @(negedge clk);                               // cycle 1
        chk("c1_rom_en",    32'(rom_en),    32'h1);
        chk("c1_rom_addr",  32'(rom_addr),  32'h0);
        chk("c1_out_valid", 32'(out_valid), 32'h0);
        nxt(); @(negedge clk);                               // cycle 2
        chk("c2_out_valid", 32'(out_valid), 32'h1);
        chk("c2_out_pc",    out_pc,         32'h0);
        for (int c = 3; c <= 5; c++) begin
            nxt(); @(negedge clk);
            chk("stream_valid", 32'(out_valid), 32'h1);
        end

        // Test 2: stall for five cycles, FIFO fills and issue stops
        nxt(); out_ready = 1'b0;                             // cycle 6
        nxt();                                               // cycle 7
        nxt(); @(negedge clk);                               // cycle 8
        chk("stall_rom_en", 32'(rom_en), 32'h0);
        chk("stall_out_pc", out_pc,      32'h10);
        nxt(); nxt(); @(negedge clk);                        // cycle 10
        chk("stall_rom_en_held", 32'(rom_en), 32'h0);
        chk("stall_occ",         32'(dut.u_fifo.occ), 32'h2);
        nxt(); out_ready = 1'b1;                             // cycle 11
        repeat (4) nxt();                                    // cycles 12..15

        // Test 3: redirect to 0x40 with a read in flight
        nxt(); redirect = 1'b1; redirect_pc = 32'h40;        // cycle 16
        @(negedge clk);
        chk("redir_rom_en", 32'(rom_en), 32'h0);
        nxt(); redirect = 1'b0;                              // cycle 17
        exp_q.delete();
        expect_one(32'h40, 32'h3c10_4000);
        expect_run(32'h44, 8);
        @(negedge clk);
        chk("redir_flush_valid", 32'(out_valid), 32'h0);
        chk("redir_rom_en_next", 32'(rom_en),    32'h1);
        chk("redir_rom_addr",    32'(rom_addr),  32'h10);
        nxt(); @(negedge clk);                               // cycle 18
        chk("redir_out_pc",    out_pc,    32'h40);
        chk("redir_out_instr", out_instr, 32'h3c10_4000);
        nxt();                                               // cycle 19

        // Test 4: misaligned redirect to 0x42
        nxt(); redirect = 1'b1; redirect_pc = 32'h42;        // cycle 20
        @(negedge clk);
        chk("align_before", 32'(align_err), 32'h0);
        nxt(); redirect = 1'b0;                              // cycle 21
        exp_q.delete();
        expect_one(32'h40, 32'h3c10_4000);
        expect_run(32'h44, 8);
        @(negedge clk);
        chk("align_pulse",    32'(align_err), 32'h1);
        chk("align_rom_addr", 32'(rom_addr),  32'h10);
        nxt(); @(negedge clk);                               // cycle 22
        chk("align_clear",  32'(align_err), 32'h0);
        chk("align_out_pc", out_pc,         32'h40);
        nxt();                                               // cycle 23

        // Test 5: address wrap at the top of the ROM
        nxt(); redirect = 1'b1; redirect_pc = 32'h7FC;       // cycle 24
        nxt(); redirect = 1'b0;                              // cycle 25
        exp_q.delete();
        expect_one(32'h7FC, 32'hDEAD_BEEF);
        expect_one(32'h800, 32'h0800_0010);
        expect_run(32'h804, 6);
        @(negedge clk);
        chk("wrap_addr_511", 32'(rom_addr), 32'h1FF);
        nxt(); @(negedge clk);                               // cycle 26
        chk("wrap_addr_0",  32'(rom_addr), 32'h0);
        chk("wrap_pc_7fc",  out_pc,        32'h7FC);
        nxt(); @(negedge clk);                               // cycle 27
        chk("wrap_pc_800",    out_pc,    32'h800);
        chk("wrap_instr_800", out_instr, 32'h0800_0010);

        // Test 6: reset with a buffered word and a read in flight
        nxt(); out_ready = 1'b0;                             // cycle 28
        nxt(); #1;                                           // cycle 29
        chk("pre_rst_valid",    32'(out_valid), 32'h1);
        chk("pre_rst_out_pc",   out_pc,         32'h804);
        chk("pre_rst_inflight", 32'(dut.inflight_reg), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid",    32'(out_valid), 32'h0);
        chk("mid_rst_out_pc",   out_pc,         32'h0);
        chk("mid_rst_instr",    out_instr,      32'h0);
        chk("mid_rst_rom_en",   32'(rom_en),    32'h0);
        chk("mid_rst_rom_addr", 32'(rom_addr),  32'h0);
        exp_q.delete();
        expect_one(32'h0, 32'h0800_0010);
        expect_one(32'h4, 32'h0000_0000);
        expect_one(32'h8, 32'h3c08_f060);
        expect_one(32'hC, 32'had00_0000);
        expect_run(32'h10, 4);
        nxt(); rst = 1'b0; out_ready = 1'b1;                 // restart cycle 0
        @(negedge clk); chk("rs_c0_rom_en", 32'(rom_en), 32'h0);
        nxt(); @(negedge clk);
        chk("rs_c1_rom_en",   32'(rom_en),   32'h1);
        chk("rs_c1_rom_addr", 32'(rom_addr), 32'h0);
        nxt(); @(negedge clk);
        chk("rs_c2_out_pc",    out_pc,    32'h0);
        chk("rs_c2_out_instr", out_instr, 32'h0800_0010);
        repeat (4) nxt();
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
